regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the ALU path and the memory-load path.
- Drives write_enable, write_addr and write_data into the register file from registered outputs.
- Keeps a per-register pending-write scoreboard. Decode reads it for hazard stalls.
- Sits between the writeback stage and the 8 x 16-bit register file.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width.
- NUM_REGS, 8, number of registers; equals 2**ADDR_W.
- MAX_WAIT, 3, consecutive lost arbitrations after which the ALU is forced to win.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  load writeback request.
- mem_addr  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request accepted this cycle.
- rsv_valid  in  1  decode reserves a destination register.
- rsv_addr  in  ADDR_W  register being reserved.
- busy  out  NUM_REGS  scoreboard; bit i=1 means a write to register i is pending.
- rsv_conflict  out  1  registered pulse: reservation hit an already-busy register.
- write_enable  out  1  to register file.
- write_addr  out  ADDR_W  to register file.
- write_data  out  DATA_W  to register file.

Behaviour:
- Reset (rst=0 at a posedge):
  - write_enable=0, write_addr=0, write_data=0, busy=0, rsv_conflict=0, wait counter=0.
  - alu_ready and mem_ready are held 0 while rst=0.
  - Requests present during reset are dropped.
  - Reset asserted mid-operation discards any transfer in that cycle. write_enable=0 after the edge.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - A requester holds valid, addr and data stable until ready.
  - ready is combinational from the valids and the wait counter. It never depends on ready.
  - At most one ready is high per cycle.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: mem wins, unless wait_cnt==MAX_WAIT, in which case alu wins.
  - Neither valid: no grant.
- Wait counter (ceil(log2(MAX_WAIT+1)) bits):
  - Increments on each cycle alu_valid=1 and alu is not granted.
  - Saturates at MAX_WAIT.
  - Clears when alu is granted or when alu_valid=0.
- Output register:
  - On the transfer edge, write_enable<=1 and write_addr/write_data<=winner's addr/data.
  - With no transfer, write_enable<=0 and write_addr/write_data hold their previous values.
  - Latency: request accepted in cycle N gives write_enable=1 during cycle N+1. The register file commits at the end of N+1.
  - Sustained throughput is one write per cycle.
- Scoreboard:
  - A transfer to register a clears busy[a] at the transfer edge.
  - rsv_valid sets busy[rsv_addr] at the same edge.
  - Set and clear of the same bit on one edge: set wins, busy stays 1.
  - A transfer to a register whose busy bit is 0 is still performed; busy is unchanged.
- Conflict flag:
  - rsv_conflict<=1 for one cycle when rsv_valid=1, busy[rsv_addr]=1, and that bit is not being cleared on the same edge.
  - Otherwise rsv_conflict<=0.
  - The reservation is still applied; the bit stays 1.
- Addresses are unsigned. No range checks are needed because NUM_REGS=2**ADDR_W.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with both valids high -> both readies 0, write_enable=0, busy=8'h00 after release.
2. Single ALU request: alu_valid=1, addr=3, data=16'h00AB in cycle N -> alu_ready=1 in N; write_enable=1, write_addr=3, write_data=16'h00AB in N+1; write_enable=0 in N+2.
3. Contention with starvation guard: both valid continuously, MAX_WAIT=3 ->
   - grants are mem, mem, mem, alu, mem, mem, mem, alu...
   - wait_cnt sequence is 1, 2, 3, 0.
4. Scoreboard: reserve r5 in cycle 0 -> busy=8'h20 in cycle 1. mem write to r5 accepted in cycle 2 -> busy=8'h00 in cycle 3, write_enable=1 in cycle 3.
5. Simultaneous set and clear: reserve r2 in the same cycle as an accepted write to r2 (busy[2]=1) -> busy[2] stays 1, rsv_conflict stays 0.
6. Conflict and mid-operation reset:
   - Reserve r1 twice with no write between -> rsv_conflict=1 for exactly one cycle.
   - Then assert rst=0 during an accepted transfer -> write_enable=0 and busy=0 after that edge.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 8 x 16-bit register file: shares one write port between
// the ALU and load writeback paths and keeps the per-register pending-write scoreboard.
module regfile_write_arbiter #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int NUM_REGS = 8,
   parameter int MAX_WAIT = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alu_valid,
   input  logic [ADDR_W-1:0]   alu_addr,
   input  logic [DATA_W-1:0]   alu_data,
   output logic                alu_ready,
   input  logic                mem_valid,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_data,
   output logic                mem_ready,
   input  logic                rsv_valid,
   input  logic [ADDR_W-1:0]   rsv_addr,
   output logic [NUM_REGS-1:0] busy,
   output logic                rsv_conflict,
   output logic                write_enable,
   output logic [ADDR_W-1:0]   write_addr,
   output logic [DATA_W-1:0]   write_data
);

   localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0]    wait_cnt;
   logic                alu_win;
   logic                mem_win;
   logic                xfer;
   logic [ADDR_W-1:0]   xfer_addr;
   logic [DATA_W-1:0]   xfer_data;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] set_mask;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      alu_win   = 1'b0;
      mem_win   = 1'b0;
      clr_mask  = '0;
      set_mask  = '0;
      // Load path has priority; a starved ALU wins once it has lost MAX_WAIT times in a row.
      if (rst) begin
         if (alu_valid && (!mem_valid || wait_cnt == WAIT_MAX))
            alu_win = 1'b1;
         else if (mem_valid)
            mem_win = 1'b1;
      end
      xfer      = alu_win | mem_win;
      xfer_addr = alu_win ? alu_addr : mem_addr;
      xfer_data = alu_win ? alu_data : mem_data;
      if (xfer)
         clr_mask[xfer_addr] = 1'b1;
      if (rsv_valid)
         set_mask[rsv_addr] = 1'b1;
   end

   assign alu_ready = alu_win;
   assign mem_ready = mem_win;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         write_enable <= 1'b0;
         write_addr   <= '0;
         write_data   <= '0;
         busy         <= '0;
         rsv_conflict <= 1'b0;
         wait_cnt     <= '0;
      end else begin
         write_enable <= xfer;
         if (xfer) begin
            write_addr <= xfer_addr;
            write_data <= xfer_data;
         end
         // Set after clear: a reservation landing with the retiring write keeps the bit busy.
         busy         <= (busy & ~clr_mask) | set_mask;
         rsv_conflict <= rsv_valid && busy[rsv_addr] && !clr_mask[rsv_addr];
         if (alu_valid && !alu_win) begin
            if (wait_cnt != WAIT_MAX)
               wait_cnt <= wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized plus directed bench for regfile_write_arbiter against a behavioural
// model of the arbitration, output register and scoreboard rules.
module tb_regfile_write_arbiter;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 8;
   localparam int MAX_WAIT = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                alu_valid, mem_valid, rsv_valid;
   logic [ADDR_W-1:0]   alu_addr, mem_addr, rsv_addr;
   logic [DATA_W-1:0]   alu_data, mem_data;
   logic                alu_ready, mem_ready;
   logic [NUM_REGS-1:0] busy;
   logic                rsv_conflict;
   logic                write_enable;
   logic [ADDR_W-1:0]   write_addr;
   logic [DATA_W-1:0]   write_data;

   regfile_write_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .busy(busy), .rsv_conflict(rsv_conflict),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit        m_we;
   int        m_wa, m_wd;
   bit        m_busy [NUM_REGS];
   bit        m_conf;
   int        m_losses;
   bit        e_ra, e_rm;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] busy_word();
      logic [31:0] w = 0;
      for (int i = 0; i < NUM_REGS; i++) if (m_busy[i]) w += (32'd1 << i);
      return w;
   endfunction

   // Grant decision from the current inputs and the count of consecutive ALU losses.
   task automatic model_grant();
      e_ra = 0;
      e_rm = 0;
      if (rst === 1'b1) begin
         if (alu_valid && mem_valid) begin
            if (m_losses == MAX_WAIT) e_ra = 1; else e_rm = 1;
         end else if (alu_valid) e_ra = 1;
         else if (mem_valid) e_rm = 1;
      end
   endtask

   task automatic model_edge();
      int  xa;
      bit  x;
      x  = e_ra || e_rm;
      xa = e_ra ? int'(alu_addr) : int'(mem_addr);
      if (rst !== 1'b1) begin
         m_we = 0; m_wa = 0; m_wd = 0; m_conf = 0; m_losses = 0;
         for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 0;
         return;
      end
      m_conf = rsv_valid && m_busy[rsv_addr] && !(x && xa == int'(rsv_addr));
      m_we = x;
      if (x) begin
         m_wa = xa;
         m_wd = e_ra ? int'(alu_data) : int'(mem_data);
         m_busy[xa] = 0;
      end
      if (rsv_valid) m_busy[rsv_addr] = 1;
      if (e_ra || !alu_valid) m_losses = 0;
      else if (m_losses < MAX_WAIT) m_losses++;
   endtask

   // One clock: inputs already driven; check readies, clock, check registered outputs.
   task automatic step();
      #1;
      model_grant();
      check("alu_ready", alu_ready, e_ra);
      check("mem_ready", mem_ready, e_rm);
      @(posedge clk);
      model_edge();
      #1;
      check("write_enable", write_enable, m_we);
      check("write_addr", write_addr, m_wa);
      check("write_data", write_data, m_wd);
      check("busy", busy, busy_word());
      check("rsv_conflict", rsv_conflict, m_conf);
   endtask

   task automatic idle();
      alu_valid = 0; mem_valid = 0; rsv_valid = 0;
   endtask

   initial begin
      rst = 0; idle();
      alu_addr = 0; alu_data = 0; mem_addr = 0; mem_data = 0; rsv_addr = 0;
      m_we = 0; m_wa = 0; m_wd = 0; m_conf = 0; m_losses = 0;
      for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 0;

      // Reset with both requests pending
      @(posedge clk); #1;
      alu_valid = 1; alu_addr = 3; alu_data = 16'h1111;
      mem_valid = 1; mem_addr = 4; mem_data = 16'h2222;
      repeat (2) begin
         #1;
         check("reset_alu_ready", alu_ready, 0);
         check("reset_mem_ready", mem_ready, 0);
         @(posedge clk); #1;
      end
      idle(); rst = 1;
      check("reset_we", write_enable, 0);
      check("reset_busy", busy, 8'h00);
      check("reset_conf", rsv_conflict, 0);
      step();

      // Single ALU request: one-cycle latency, then write_enable drops
      alu_valid = 1; alu_addr = 3; alu_data = 16'h00AB;
      step();
      check("alu_single_addr", write_addr, 3);
      check("alu_single_data", write_data, 16'h00AB);
      idle(); step();
      check("alu_single_we_off", write_enable, 0);

      // Contention: ALU gets every fourth slot
      alu_valid = 1; mem_valid = 1;
      for (int c = 0; c < 8; c++) begin
         alu_addr = 3'(c); alu_data = 16'(16'hA000 + c);
         mem_addr = 3'(7 - c); mem_data = 16'(16'hB000 + c);
         #1;
         check("starve_alu_grant", alu_ready, (c % 4 == 3) ? 1 : 0);
         check("starve_mem_grant", mem_ready, (c % 4 == 3) ? 0 : 1);
         #0 step();
      end
      idle(); step();

      // Scoreboard set by reservation, cleared by write
      rsv_valid = 1; rsv_addr = 5; step();
      check("sb_set", busy, 8'h20);
      idle(); step();
      mem_valid = 1; mem_addr = 5; mem_data = 16'h5555; step();
      check("sb_clear", busy, 8'h00);
      check("sb_we", write_enable, 1);
      idle(); step();

      // Simultaneous set and clear of r2
      rsv_valid = 1; rsv_addr = 2; step();
      mem_valid = 1; mem_addr = 2; mem_data = 16'h2020; rsv_valid = 1; rsv_addr = 2; step();
      check("setclr_busy2", busy[2], 1);
      check("setclr_conf", rsv_conflict, 0);
      idle(); step();

      // Double reservation then mid-operation reset
      rsv_valid = 1; rsv_addr = 1; step();
      step();
      check("conf_pulse", rsv_conflict, 1);
      idle(); step();
      check("conf_once", rsv_conflict, 0);
      alu_valid = 1; alu_addr = 6; alu_data = 16'h6666; rst = 0; step();
      check("midrst_we", write_enable, 0);
      check("midrst_busy", busy, 8'h00);
      rst = 1; idle(); step();

      // Randomized traffic with held requests and occasional reset
      for (int n = 0; n < 3000; n++) begin
         if (alu_valid && alu_ready) alu_valid = 0;
         if (mem_valid && mem_ready) mem_valid = 0;
         if (rst == 0) begin alu_valid = 0; mem_valid = 0; end
         rst = ($urandom_range(0, 60) != 0);
         if (!alu_valid && $urandom_range(0, 3) != 0) begin
            alu_valid = 1; alu_addr = 3'($urandom); alu_data = 16'($urandom);
         end
         if (!mem_valid && $urandom_range(0, 2) != 0) begin
            mem_valid = 1; mem_addr = 3'($urandom); mem_data = 16'($urandom);
         end
         rsv_valid = ($urandom_range(0, 2) == 0);
         rsv_addr  = 3'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
